// File: rtl/axi4_stream_arbiter.sv
// axi4_stream_arbiter: packet-granular round-robin AXI4-Stream arbiter.
// A grant locks from the first beat until tlast is accepted downstream.
module axi4_stream_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 64,
  parameter int IDX_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [NUM_PORTS-1:0]               port_en,
  input  logic [NUM_PORTS-1:0]               s_tvalid,
  output logic [NUM_PORTS-1:0]               s_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    s_tdata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] s_tstrb,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]               s_tlast,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]      s_tid,
  input  logic [NUM_PORTS*DEST_WIDTH-1:0]    s_tdest,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]    s_tuser,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic [DATA_WIDTH-1:0]              m_tdata,
  output logic [DATA_WIDTH/8-1:0]            m_tstrb,
  output logic [DATA_WIDTH/8-1:0]            m_tkeep,
  output logic                               m_tlast,
  output logic [ID_WIDTH-1:0]                m_tid,
  output logic [DEST_WIDTH-1:0]              m_tdest,
  output logic [USER_WIDTH-1:0]              m_tuser,
  output logic                               grant_valid,
  output logic [IDX_WIDTH-1:0]               grant_idx
);

  localparam int KW = DATA_WIDTH / 8;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_WIDTH-1:0] grant_q, grant_d;
  logic [IDX_WIDTH-1:0] pick;
  logic [NUM_PORTS-1:0] req;
  logic                 locked;
  int                   gi;

  function automatic logic [IDX_WIDTH-1:0] wrap_idx(
    input logic [IDX_WIDTH-1:0] base,
    input int                   off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return IDX_WIDTH'(s);
  endfunction

  assign req    = s_tvalid & port_en;
  assign locked = (state_q == LOCKED);
  assign gi     = int'(grant_q);

  // Descending scan: the last hit written is the nearest one from rr_ptr.
  always_comb begin
    pick = rr_ptr_q;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[wrap_idx(rr_ptr_q, i)]) pick = wrap_idx(rr_ptr_q, i);
    end
  end

  assign m_tdata  = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
  assign m_tstrb  = s_tstrb[gi*KW +: KW];
  assign m_tkeep  = s_tkeep[gi*KW +: KW];
  assign m_tlast  = s_tlast[grant_q];
  assign m_tid    = s_tid[gi*ID_WIDTH +: ID_WIDTH];
  assign m_tdest  = s_tdest[gi*DEST_WIDTH +: DEST_WIDTH];
  assign m_tuser  = s_tuser[gi*USER_WIDTH +: USER_WIDTH];
  assign m_tvalid = locked & s_tvalid[grant_q];

  always_comb begin
    s_tready = '0;
    if (locked) s_tready[grant_q] = m_tready;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = LOCKED;
          grant_d = pick;
        end
      end
      LOCKED: begin
        if (m_tvalid && m_tready && m_tlast) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == IDX_WIDTH'(NUM_PORTS - 1)) ?
                     '0 : grant_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  assign grant_valid = locked;
  assign grant_idx   = grant_q;

endmodule

// File: tb/tb_axi4_stream_arbiter.sv
// tb_axi4_stream_arbiter: scoreboard bench for the round-robin arbiter.
// Source models emit {port, seq} beats; expectations are queued per test.
`timescale 1ns/1ps
module tb_axi4_stream_arbiter;
  localparam int NP  = 4;
  localparam int DW  = 64;
  localparam int KW  = DW / 8;
  localparam int IW  = 8;
  localparam int DSW = 8;
  localparam int UW  = 64;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NP-1:0]     port_en;
  logic [NP-1:0]     s_tvalid;
  logic [NP-1:0]     s_tready;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*KW-1:0]  s_tstrb;
  logic [NP*KW-1:0]  s_tkeep;
  logic [NP-1:0]     s_tlast;
  logic [NP*IW-1:0]  s_tid;
  logic [NP*DSW-1:0] s_tdest;
  logic [NP*UW-1:0]  s_tuser;
  logic              m_tvalid;
  logic              m_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tstrb;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic [IW-1:0]     m_tid;
  logic [DSW-1:0]    m_tdest;
  logic [UW-1:0]     m_tuser;
  logic              grant_valid;
  logic [1:0]        grant_idx;

  logic [NP-1:0] src_v;
  int seq [NP];
  int pos [NP];
  int len [NP];
  int nxt [NP];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  port;
    logic [63:0] data;
    logic        last;
    logic        chg;
    logic [3:0]  nv;
    logic [3:0]  ne;
  } exp_t;
  exp_t sb [$];

  always #5 aclk = ~aclk;

  axi4_stream_arbiter dut (
    .aclk(aclk), .areset(areset), .port_en(port_en),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  always_comb begin
    s_tvalid = src_v;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    s_tid    = '0;
    s_tdest  = '0;
    s_tuser  = '0;
    for (int p = 0; p < NP; p++) begin
      s_tdata[p*DW +: DW]   = {32'(p), 32'(seq[p])};
      s_tuser[p*UW +: UW]   = ~{32'(p), 32'(seq[p])};
      s_tlast[p]            = (pos[p] == len[p] - 1);
      s_tstrb[p*KW +: KW]   = 8'(p * 17 + 1);
      s_tkeep[p*KW +: KW]   = 8'(8'hFF >> p);
      s_tid[p*IW +: IW]     = 8'(16 + p);
      s_tdest[p*DSW +: DSW] = 8'(32 + p);
    end
  end

  always @(posedge aclk) begin
    for (int p = 0; p < NP; p++) begin
      if (areset) begin
        pos[p] <= 0;
        seq[p] <= 0;
      end else if (s_tvalid[p] && s_tready[p]) begin
        seq[p] <= seq[p] + 1;
        pos[p] <= s_tlast[p] ? 0 : pos[p] + 1;
      end
    end
  end

  function automatic void sync_nxt();
    for (int p = 0; p < NP; p++) nxt[p] = seq[p];
  endfunction

  function automatic void push_pkt(input int p, input int n, input logic chg,
                                   input logic [3:0] nv, input logic [3:0] ne);
    exp_t x;
    for (int k = 0; k < n; k++) begin
      x.port = 2'(p);
      x.data = {32'(p), 32'(nxt[p])};
      x.last = (k == n - 1);
      x.chg  = chg && (k == n - 1);
      x.nv   = nv;
      x.ne   = ne;
      sb.push_back(x);
      nxt[p]++;
    end
  endfunction

  task automatic test_reset();
    areset   = 1'b1;
    src_v    = 4'hF;
    port_en  = 4'hF;
    m_tready = 1'b0;
    for (int p = 0; p < NP; p++) len[p] = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      n_checks++;
      if ({m_tvalid, s_tready, grant_valid, grant_idx} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_hold: got valid=%b ready=%b gv=%b idx=%0d, expected all 0",
                 m_tvalid, s_tready, grant_valid, grant_idx);
      end
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    n_checks++;
    if (grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got gv=%b, expected 0", grant_valid);
    end
    @(negedge aclk);
    n_checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd0 || m_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: got gv=%b idx=%0d valid=%b, expected 1 0 1",
               grant_valid, grant_idx, m_tvalid);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   c0 = 0;
    int   k = 0;
    logic do_chg = 1'b0;
    sync_nxt();
    push_pkt(0, 2, 1'b0, 4'h0, 4'h0);
    push_pkt(1, 2, 1'b0, 4'h0, 4'h0);
    push_pkt(2, 2, 1'b0, 4'h0, 4'h0);
    push_pkt(3, 2, 1'b0, 4'h0, 4'h0);
    push_pkt(0, 2, 1'b1, 4'h0, 4'hF);
    @(posedge aclk); #1;
    m_tready = 1'b1;
    for (int cyc = 0; cyc < 60 && sb.size() != 0; cyc++) begin
      @(negedge aclk);
      if (m_tvalid && m_tready) begin
        e = sb.pop_front();
        if (k == 0) c0 = cyc;
        n_checks++;
        if (grant_idx !== e.port || m_tdata !== e.data || m_tlast !== e.last) begin
          n_fail++;
          $display("FAIL rr_beat%0d: got port=%0d data=%h last=%b, expected %0d %h %b",
                   k, grant_idx, m_tdata, m_tlast, e.port, e.data, e.last);
        end
        n_checks++;
        if (cyc - c0 != (k / 2) * 3 + k % 2) begin
          n_fail++;
          $display("FAIL rr_timing%0d: got offset %0d, expected %0d",
                   k, cyc - c0, (k / 2) * 3 + k % 2);
        end
        n_checks++;
        if ({m_tid, m_tdest, m_tstrb, m_tkeep} !==
            {8'(16 + int'(e.port)), 8'(32 + int'(e.port)),
             8'(int'(e.port) * 17 + 1), 8'(8'hFF >> e.port)} ||
            m_tuser !== ~e.data) begin
          n_fail++;
          $display("FAIL rr_sideband%0d: got id=%h dest=%h strb=%h keep=%h user=%h",
                   k, m_tid, m_tdest, m_tstrb, m_tkeep, m_tuser);
        end
        k++;
        do_chg = e.chg;
      end
      @(posedge aclk); #1;
      if (do_chg) begin
        src_v   = e.nv;
        port_en = e.ne;
        do_chg  = 1'b0;
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d beats outstanding, expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_packet_lock();
    exp_t e;
    int   k = 0;
    logic do_chg = 1'b0;
    len[1] = 5;
    len[0] = 2;
    sync_nxt();
    push_pkt(1, 5, 1'b0, 4'h0, 4'h0);
    push_pkt(0, 2, 1'b1, 4'h0, 4'hF);
    src_v    = 4'b0011;
    m_tready = 1'b1;
    for (int cyc = 0; cyc < 60 && sb.size() != 0; cyc++) begin
      @(negedge aclk);
      if (grant_valid && grant_idx == 2'd1) begin
        n_checks++;
        if (s_tready[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL lock_ready0: got s_tready=%b, expected bit0 0", s_tready);
        end
      end
      if (m_tvalid && m_tready) begin
        e = sb.pop_front();
        n_checks++;
        if (grant_idx !== e.port || m_tdata !== e.data || m_tlast !== e.last) begin
          n_fail++;
          $display("FAIL lock_beat%0d: got port=%0d data=%h last=%b, expected %0d %h %b",
                   k, grant_idx, m_tdata, m_tlast, e.port, e.data, e.last);
        end
        k++;
        do_chg = e.chg;
      end
      @(posedge aclk); #1;
      m_tready = ~m_tready;
      if (do_chg) begin
        src_v   = e.nv;
        port_en = e.ne;
        do_chg  = 1'b0;
      end
    end
    m_tready = 1'b1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL lock_timeout: got %0d beats outstanding, expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_wrap_skip();
    exp_t e;
    int   k = 0;
    logic do_chg = 1'b0;
    len[2] = 1;
    len[1] = 2;
    sync_nxt();
    push_pkt(2, 1, 1'b1, 4'b1010, 4'b0111);
    push_pkt(1, 2, 1'b1, 4'b1111, 4'b1111);
    push_pkt(2, 1, 1'b1, 4'b0000, 4'b1111);
    src_v   = 4'b0100;
    port_en = 4'hF;
    for (int cyc = 0; cyc < 60 && sb.size() != 0; cyc++) begin
      @(negedge aclk);
      if (m_tvalid && m_tready) begin
        e = sb.pop_front();
        n_checks++;
        if (grant_idx !== e.port || m_tdata !== e.data || m_tlast !== e.last) begin
          n_fail++;
          $display("FAIL wrap_beat%0d: got port=%0d data=%h last=%b, expected %0d %h %b",
                   k, grant_idx, m_tdata, m_tlast, e.port, e.data, e.last);
        end
        k++;
        do_chg = e.chg;
      end
      @(posedge aclk); #1;
      if (do_chg) begin
        src_v   = e.nv;
        port_en = e.ne;
        do_chg  = 1'b0;
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_timeout: got %0d beats outstanding, expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   k = 0;
    int   stall = 0;
    logic do_chg = 1'b0;
    len[3] = 4;
    sync_nxt();
    push_pkt(3, 4, 1'b1, 4'h0, 4'hF);
    src_v    = 4'b1000;
    m_tready = 1'b1;
    for (int cyc = 0; cyc < 60 && sb.size() != 0; cyc++) begin
      @(negedge aclk);
      if (!m_tready && grant_valid) begin
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== sb[0].data ||
            s_tready !== 4'b0000 || grant_idx !== 2'd3) begin
          n_fail++;
          $display("FAIL bp_stall: got valid=%b data=%h ready=%b idx=%0d, expected 1 %h 0000 3",
                   m_tvalid, m_tdata, s_tready, grant_idx, sb[0].data);
        end
      end
      if (m_tvalid && m_tready) begin
        e = sb.pop_front();
        if (k == 0) stall = 10;
        n_checks++;
        if (grant_idx !== e.port || m_tdata !== e.data || m_tlast !== e.last) begin
          n_fail++;
          $display("FAIL bp_beat%0d: got port=%0d data=%h last=%b, expected %0d %h %b",
                   k, grant_idx, m_tdata, m_tlast, e.port, e.data, e.last);
        end
        k++;
        do_chg = e.chg;
      end
      @(posedge aclk); #1;
      m_tready = (stall == 0);
      if (stall > 0) stall--;
      if (do_chg) begin
        src_v   = e.nv;
        port_en = e.ne;
        do_chg  = 1'b0;
      end
    end
    m_tready = 1'b1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_timeout: got %0d beats outstanding, expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_mid_reset();
    logic [63:0] d;
    int          b;
    len[2]   = 4;
    b        = seq[2];
    src_v    = 4'b0100;
    port_en  = 4'hF;
    m_tready = 1'b1;
    @(negedge aclk);
    for (int k = 0; k < 3; k++) begin
      @(posedge aclk); #1;
      if (k == 2) areset = 1'b1;
      @(negedge aclk);
      d = {32'd2, 32'(b + k)};
      n_checks++;
      if (m_tvalid !== 1'b1 || grant_idx !== 2'd2 || m_tdata !== d) begin
        n_fail++;
        $display("FAIL midrst_beat%0d: got valid=%b idx=%0d data=%h, expected 1 2 %h",
                 k, m_tvalid, grant_idx, m_tdata, d);
      end
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    src_v  = 4'b0000;
    @(negedge aclk);
    n_checks++;
    if ({m_tvalid, s_tready, grant_valid, grant_idx} !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_after: got valid=%b ready=%b gv=%b idx=%0d, expected all 0",
               m_tvalid, s_tready, grant_valid, grant_idx);
    end
    @(posedge aclk); #1;
    src_v = 4'b1111;
    @(negedge aclk);
    @(negedge aclk);
    n_checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_regrant: got gv=%b idx=%0d, expected 1 0",
               grant_valid, grant_idx);
    end
    src_v = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_wrap_skip();
    test_backpressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
